// File: rtl/alu_li_pkg.sv
// rtl/alu_li_pkg.sv - shared opcode definitions for the pipelined ALU
package alu_li_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,
    OP_XOR = 2'd3
  } op_e;

endpackage

// File: rtl/alu_li_fifo.sv
// rtl/alu_li_fifo.sv - result queue; occupancy tracked by count, pointers wrap modulo DEPTH
module alu_li_fifo
  import alu_li_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  // A pop on empty is ignored; a push is taken when there is room or a pop frees a slot this cycle.
  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless unless counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_li_pipe.sv
// rtl/alu_li_pipe.sv - credit-based pipelined ALU with output queue; optional stats via ALU_LI_PIPE_STATS_EN
module alu_li_pipe
  import alu_li_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] result_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef ALU_LI_PIPE_STATS_EN
  ,
  output logic [31:0]      stat_accepted,
  output logic [31:0]      stat_completed,
  output logic [31:0]      stat_stall
`endif
);

  localparam int CRD_W = $clog2(DEPTH + 1);

  logic [CRD_W-1:0] credits_q, credits_d;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] calc;
  logic [WIDTH-1:0] res_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0] head;
  logic [CRD_W-1:0] occupancy;

  // Credits cover both in-flight and buffered results, so the queue can never overflow.
  assign ready_out = (credits_q != '0);
  assign accept    = valid_in && ready_out;
  assign pop       = valid_out && ready_in;

  // Credit bookkeeping: accept consumes one, pop returns one, both together cancel.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CRD_W'(1);
    end else if (pop && !accept) begin
      credits_d = credits_q + CRD_W'(1);
    end
  end

  // Credit register; a reset returns every credit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q <= CRD_W'(DEPTH);
    end else begin
      credits_q <= credits_d;
    end
  end

  // Modulo-2^WIDTH arithmetic; the result width truncates add/sub/mul.
  always_comb begin
    calc = '0;
    case (op_e'(op_in))
      OP_ADD:  calc = a_in + b_in;
      OP_MUL:  calc = a_in * b_in;
      OP_SUB:  calc = a_in - b_in;
      OP_XOR:  calc = a_in ^ b_in;
      default: calc = '0;
    endcase
  end

  // Delay line: stage 0 loads only on accept; valid bits carry bubbles so stale data never pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        res_q[0] <= calc;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  alu_li_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (vld_q[LATENCY-1]),
    .push_data_i (res_q[LATENCY-1]),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (occupancy)
  );

  assign valid_out  = (occupancy != '0);
  assign result_out = valid_out ? head : '0;

`ifdef ALU_LI_PIPE_STATS_EN
  logic [31:0] stat_accepted_q;
  logic [31:0] stat_completed_q;
  logic [31:0] stat_stall_q;

  // Saturating event counters for accepts, pops and back-pressured input cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_accepted_q  <= '0;
      stat_completed_q <= '0;
      stat_stall_q     <= '0;
    end else begin
      if (accept && (stat_accepted_q != 32'hFFFF_FFFF)) begin
        stat_accepted_q <= stat_accepted_q + 32'd1;
      end
      if (pop && (stat_completed_q != 32'hFFFF_FFFF)) begin
        stat_completed_q <= stat_completed_q + 32'd1;
      end
      if (valid_in && !ready_out && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_accepted  = stat_accepted_q;
  assign stat_completed = stat_completed_q;
  assign stat_stall     = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_li_pipe.sv
// tb/tb_alu_li_pipe.sv - self-checking bench for alu_li_pipe with a timestamped scoreboard model
module tb_alu_li_pipe;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [1:0]   op_in = '0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [W-1:0] result_out;
  logic         valid_out;
  logic         ready_in = 1'b0;
`ifdef ALU_LI_PIPE_STATS_EN
  logic [31:0]  stat_accepted;
  logic [31:0]  stat_completed;
  logic [31:0]  stat_stall;
`endif

  alu_li_pipe #(
    .WIDTH   (W),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .result_out (result_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in)
`ifdef ALU_LI_PIPE_STATS_EN
    ,
    .stat_accepted  (stat_accepted),
    .stat_completed (stat_completed),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic [W-1:0] exp_q[$];
  int           arr_q[$];
  logic [W-1:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      2'd2:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Checks settled outputs against the model, then advances one clock.
  // Each scoreboard entry records the edge count at which it becomes visible.
  task automatic tick();
    bit           ev;
    bit           acc;
    bit           pp;
    logic [W-1:0] e;
    ev = (exp_q.size() > 0) && (arr_q[0] <= cyc);
    chk("ready_out", ready_out, exp_q.size() < DEP);
    chk("valid_out", valid_out, ev);
    if (ev) chk("result_out", result_out, exp_q[0]);
    acc = valid_in && (exp_q.size() < DEP);
    pp  = ev && ready_in;
    e   = ref_alu(op_in, a_in, b_in);
    if (pp) begin
      got_q.push_back(result_out);
      void'(exp_q.pop_front());
      void'(arr_q.pop_front());
      n_pop++;
    end
    if (acc) begin
      exp_q.push_back(e);
      arr_q.push_back(cyc + 1 + LAT);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    ready_in = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset valid_out", valid_out, 0);
    chk("reset result_out", result_out, 0);
    exp_q.delete();
    arr_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("ready_out after reset", ready_out, 1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) tick();
    chk("drain empty", exp_q.size(), 0);
  endtask

  task automatic rand_op();
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    op_in = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int           acc_obs;
    int           low;
    int           bub;
    logic [W-1:0] held;

    #2;
    do_reset();

    // Scenario 1: single add, visible LAT edges after accept for one cycle
    a_in = 3; b_in = 5; op_in = 2'd0; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < LAT - 1; i++) tick();
    chk("s1 not yet valid", valid_out, 0);
    tick();
    chk("s1 valid", valid_out, 1);
    chk("s1 result", result_out, 8);
    tick();
    chk("s1 single cycle", valid_out, 0);

    // Scenario 2: wrap-around mul and sub, in order
    got_q.delete();
    a_in = 32'hFFFF_FFFF; b_in = 2; op_in = 2'd1; valid_in = 1'b1;
    tick();
    a_in = 0; b_in = 1; op_in = 2'd2;
    tick();
    valid_in = 1'b0;
    drain();
    chk("s2 count", got_q.size(), 2);
    chk("s2 mul", got_q[0], 32'hFFFF_FFFE);
    chk("s2 sub", got_q[1], 32'hFFFF_FFFF);

    // Scenario 3/6: back-pressure fills exactly DEP credits, then drains in order
    do_reset();
    got_q.delete();
    n_pop = 0;
    acc_obs = 0;
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_op();
      if (valid_in && ready_out) acc_obs++;
      tick();
    end
    valid_in = 1'b0;
    chk("s3 accepts", acc_obs, DEP);
    chk("s3 ready_out low", ready_out, 0);
`ifdef ALU_LI_PIPE_STATS_EN
    chk("s6 stat_accepted", stat_accepted, DEP);
    chk("s6 stat_stall", stat_stall, 10 - DEP);
`endif
    held = result_out;
    for (int i = 0; i < 3; i++) tick();
    chk("s3 head stable", result_out, held);
    ready_in = 1'b1;
    drain();
    chk("s3 pops", n_pop, DEP);
    chk("s3 results", got_q.size(), DEP);
`ifdef ALU_LI_PIPE_STATS_EN
    chk("s6 stat_completed", stat_completed, DEP);
`endif

    // Scenario 4: 100 back-to-back random ops at full throughput
    n_pop = 0;
    low = 0;
    bub = 0;
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_op();
      if (!ready_out) low++;
      if (i > LAT && !valid_out) bub++;
      tick();
    end
    valid_in = 1'b0;
    drain();
    chk("s4 pops", n_pop, 100);
    chk("s4 ready_out low cycles", low, 0);
    chk("s4 bubbles", bub, 0);

    // Scenario 5: reset with two in flight and one buffered
    do_reset();
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      tick();
    end
    valid_in = 1'b0;
    chk("s5 buffered before reset", valid_out, 1);
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("s5 no stale result", valid_out, 0);
    chk("s5 ready_out", ready_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_li_pipe.md
ALU_LI_PIPE -- requirements
Module: alu_li_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter LATENCY, default 2: compute pipeline depth in cycles (legal 1..8).
REQ-003 The block SHALL have parameter DEPTH, default 4: total credits, in-flight plus buffered results (legal LATENCY+1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports a_in and b_in, input, WIDTH bits each: operands.
REQ-007 The block SHALL have port op_in, input, 2 bits: opcode, 0 add, 1 mul, 2 sub (a-b), 3 xor.
REQ-008 The block SHALL have ports valid_in (input, 1 bit) and ready_out (output, 1 bit): the input handshake.
REQ-009 The block SHALL have port result_out, output, WIDTH bits: head-of-queue result.
REQ-010 The block SHALL have ports valid_out (output, 1 bit) and ready_in (input, 1 bit): the output handshake.

Function
REQ-011 The block SHALL accept an operation at a rising edge where valid_in && ready_out; no other condition accepts.
REQ-012 Arithmetic SHALL be modulo 2^WIDTH: add, sub and mul keep the low WIDTH bits; xor is bitwise.
REQ-013 An operation accepted at edge t SHALL enter the output queue at edge t+LATENCY, with valid_out high from then on.
REQ-014 ready_out SHALL equal (inflight + occupancy) < DEPTH, driven from registers only and independent of ready_in and valid_in.
REQ-015 The credit count SHALL decrement on accept, increment on pop (valid_out && ready_in), and stay unchanged when both occur in one cycle.
REQ-016 valid_out SHALL be high exactly when the queue is non-empty; result_out SHALL equal the queue head.
REQ-017 result_out SHALL be held stable while valid_out && !ready_in.
REQ-018 Results SHALL leave in acceptance order, with no drop or duplication under any ready_in pattern.
REQ-019 With ready_in held at 1, the block SHALL sustain one accept and one pop per cycle indefinitely.
REQ-020 When the queue is full, a simultaneous pop and pipeline arrival SHALL be legal and leave occupancy unchanged.
REQ-021 Queue pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by a count, not by pointer equality.
REQ-022 With valid_in low, pipeline stages SHALL carry bubbles, and operands from cycles without an accept SHALL never reach the queue.

Reset
REQ-023 Asserting reset SHALL immediately clear pipeline valid bits, queue pointers, occupancy and in-flight count, drive result_out to 0 and valid_out to 0, and (with the statistics feature compiled in) zero the statistics counters.
REQ-024 An assertion of reset mid-operation SHALL discard all in-flight and buffered results.
REQ-025 ready_out SHALL be 1 at the first rising edge after reset deasserts.

Configuration
REQ-026 With macro ALU_LI_PIPE_STATS_EN defined, the block SHALL add 32-bit outputs stat_accepted, stat_completed and stat_stall; these count accepts, pops, and cycles with valid_in && !ready_out, each saturating at 0xFFFFFFFF.
REQ-027 Without ALU_LI_PIPE_STATS_EN, those ports and counters SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-028 The opcode enum (OP_ADD, OP_MUL, OP_SUB, OP_XOR) and the opcode width constant SHALL live in shared package alu_li_pkg.
REQ-029 The output queue SHALL be the sub-module alu_li_fifo, parametrised by WIDTH and DEPTH, with push/pop/count ports.

Verification
REQ-030 Scenario 1: after reset, accept a=3, b=5, op=0 with ready_in=1 -> valid_out rises LATENCY edges later with result_out=8, for one cycle.
REQ-031 Scenario 2: with WIDTH=32, a=0xFFFFFFFF, b=2, op=1, then op=2 with a=0, b=1 -> results 0xFFFFFFFE, then 0xFFFFFFFF, in order.
REQ-032 Scenario 3: ready_in=0, valid_in held 1 -> exactly DEPTH accepts, then ready_out=0; raise ready_in -> DEPTH results in order, each stable while stalled.
REQ-033 Scenario 4: ready_in=1, 100 back-to-back random ops -> 100 results matching a reference model, ready_out never low, zero bubbles after the first LATENCY cycles.
REQ-034 Scenario 5: assert reset with 2 in flight and 1 buffered -> valid_out=0 immediately, no stale result after release, ready_out=1.
REQ-035 Scenario 6 (ALU_LI_PIPE_STATS_EN defined): run Scenario 3 with valid_in held 1 for 10 cycles -> stat_accepted=DEPTH, stat_stall=10-DEPTH, stat_completed=DEPTH after drain.
